mnist_pixel_feeder: RTL
=======================

Name: mnist_pixel_feeder

Overview:
- Frame-buffered pixel source that drives the network's input stream (`input_vld`/`input_din`) with one 28x28 8-bit grayscale image per frame, in raster order.
- Host side loads the image through a simple write port, then pulses `start`. The block replays the frame with programmable inter-pixel spacing and `ce` throttling.
- Transmit end of the pixel-stream interface consumed by the network top level.

Parameters:
- N, 8, pixel width in bits
- IMG_SIZE, 28, image side length; NUM_PIX = IMG_SIZE*IMG_SIZE = 784
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= NUM_PIX
- PIXEL_GAP, 0, idle cycles inserted between consecutive pixels (0 = back-to-back)

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- ce  input  1  stream enable; gates issue of new pixels only
- wr_en  input  1  frame-buffer write strobe
- wr_addr  input  ADDR_W  write address, 0..NUM_PIX-1
- wr_data  input  N  pixel value to store
- wr_ignored  output  1  one-cycle pulse: write rejected (busy, or address out of range)
- start  input  1  begin streaming the buffered frame
- busy  output  1  frame transmission in progress
- pixel_vld  output  1  pixel valid; connects to `input_vld` of the network top
- pixel_dout  output  N  pixel value; connects to `input_din`
- pixel_idx  output  ADDR_W  raster index of the current pixel
- frame_last  output  1  high together with `pixel_vld` on pixel NUM_PIX-1
- done  output  1  one-cycle pulse after the last pixel

Behaviour:
- Reset values: `busy`, `pixel_vld`, `frame_last`, `done` and `wr_ignored` = 0; `pixel_dout` and `pixel_idx` = 0; FSM in IDLE; read and gap counters cleared.
- Frame buffer:
  - NUM_PIX x N RAM with a synchronous read (1-cycle latency). RAM contents are not reset.
  - A write is accepted only when in IDLE and `wr_addr` < NUM_PIX.
  - Any other write is dropped, and `wr_ignored` pulses on the cycle after it.
- FSM states and transitions:
  - IDLE -> SEND when `start`=1 is sampled.
  - SEND -> IDLE after the read of index NUM_PIX-1 has been issued and its pixel emitted.
- Issue rule in SEND:
  - A read is issued when gap counter = 0 and `ce`=1. Read index starts at 0.
  - On issue, the read index increments and the gap counter loads PIXEL_GAP.
  - The gap counter decrements only on cycles where `ce`=1.
  - With `ce`=0, nothing is issued and all counters freeze.
- Output timing:
  - A read issued at cycle t produces `pixel_vld`=1 at t+1, with `pixel_dout` = buffer[idx] and `pixel_idx` = idx.
  - This holds even if `ce` drops at t+1.
  - Outside valid cycles, `pixel_vld`=0 and `pixel_dout`/`pixel_idx` hold their last values.
- Latency and rate:
  - `start` sampled at cycle T gives the first pixel at T+2. The first read is issued at T+1 if `ce`=1.
  - With `ce` held high, pixels appear every PIXEL_GAP+1 cycles.
  - With PIXEL_GAP=0, pixels occupy T+2..T+785.
- End of frame:
  - `frame_last`=1 only with pixel NUM_PIX-1.
  - `done` pulses on the cycle after the last pixel.
  - `busy` is high from T+1 through the last-pixel cycle and low from the `done` cycle onward.
  - The FSM is in IDLE during the `done` cycle, so a `start` sampled in that cycle is accepted.
- `start` while in SEND is ignored.
- `wr_en` and `start` in the same IDLE cycle: the write is performed, streaming begins, and the new value is visible, since the RAM read occurs a cycle later.
- `rst_n` asserted mid-frame: all outputs clear immediately (asynchronous), no `done` pulse is generated, and buffer contents are retained.

Test Plan:
- Load buffer[i] = i mod 256, PIXEL_GAP=0, `ce`=1, `start` at cycle T -> 784 consecutive `pixel_vld` cycles T+2..T+785 carrying 0,1,…,255,0,…,15 with `pixel_idx` 0..783; `frame_last` at T+785; `done` at T+786; `busy` high T+1..T+785.
- PIXEL_GAP=2, same frame -> pixels at T+2, T+5, T+8, …; last pixel at T+2+3*783 = T+2351; `done` at T+2352.
- Drop `ce` low for 10 cycles after pixel 100 (PIXEL_GAP=0) -> no `pixel_vld` during the stall; pixel 101 is the first pixel after `ce` returns; no index skipped or duplicated; total of 784 pixels.
- `wr_en` during SEND, and `wr_en` with `wr_addr`=800 in IDLE -> `wr_ignored` pulses on the next cycle, the buffer is unchanged, and a replay shows the original data.
- `start` re-pulsed mid-frame, then again during the `done` cycle -> first is ignored (single 784-pixel frame); second starts a new frame with the first pixel two cycles later.
- `rst_n` low at pixel 400 for 3 cycles, then `start` -> outputs are 0 during reset, no `done`, and the full frame replays from index 0 with the original data.

Source files
------------

// File: rtl/mnist_pixel_feeder.sv
// Frame-buffered 28x28 pixel source for the network input stream.
// Host loads the buffer while idle, then a start pulse replays it in raster order.
module mnist_pixel_feeder #(
    parameter int N         = 8,
    parameter int IMG_SIZE  = 28,
    parameter int ADDR_W    = 10,
    parameter int PIXEL_GAP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [N-1:0]      wr_data,
    output logic              wr_ignored,
    input  logic              start,
    output logic              busy,
    output logic              pixel_vld,
    output logic [N-1:0]      pixel_dout,
    output logic [ADDR_W-1:0] pixel_idx,
    output logic              frame_last,
    output logic              done
);

    localparam int NUM_PIX = IMG_SIZE * IMG_SIZE;
    localparam int GAP_W   = (PIXEL_GAP > 0) ? $clog2(PIXEL_GAP + 1) : 1;

    localparam logic [ADDR_W:0]  PIX_CNT  = (ADDR_W + 1)'(NUM_PIX);
    localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W + 1)'(NUM_PIX - 1);
    localparam logic [GAP_W-1:0] GAP_LD   = GAP_W'(PIXEL_GAP);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [N-1:0]     mem [NUM_PIX];
    // One extra bit so "all pixels issued" is representable
    logic [ADDR_W:0]  rd_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             wr_ok;
    logic             issue;

    assign wr_ok = wr_en && (state == IDLE)
                && ({1'b0, wr_addr} < PIX_CNT);

    assign issue = (state == SEND) && ce
                && (gap_cnt == '0) && (rd_idx < PIX_CNT);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_idx     <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            pixel_vld  <= 1'b0;
            pixel_dout <= '0;
            pixel_idx  <= '0;
            frame_last <= 1'b0;
            done       <= 1'b0;
            wr_ignored <= 1'b0;
        end else begin
            wr_ignored <= wr_en && !wr_ok;
            done       <= 1'b0;
            pixel_vld  <= issue;
            frame_last <= issue && (rd_idx == LAST_IDX);

            if (issue) begin
                pixel_dout <= mem[rd_idx[ADDR_W-1:0]];
                pixel_idx  <= rd_idx[ADDR_W-1:0];
                rd_idx     <= rd_idx + 1'b1;
                gap_cnt    <= GAP_LD;
            end else if ((state == SEND) && ce && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SEND;
                        busy    <= 1'b1;
                        rd_idx  <= '0;
                        gap_cnt <= '0;
                    end
                end
                SEND: begin
                    // Leave on the cycle the last pixel is on the bus
                    if (frame_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
